// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the PC stage: reset/trap defaults, next-PC source
// select encoding, stage state encoding and a small alignment helper.
package pc_next_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // A fetch address is legal only when word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_unit_next_pc_mux.sv
// Combinational next-PC selection: builds the four candidate targets from the
// current pc and picks one by priority jr > jump > branch > sequential.
module next_pc_mux
  import pc_next_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump,
  input  logic [27:0] i_jump_low,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_misaligned
);

  logic [31:0] w_seq;
  logic [31:0] w_br;
  logic [31:0] w_jmp;
  logic [31:0] w_jra;
  sel_e        w_sel;

  assign w_seq = i_pc + 32'd4;
  assign w_br  = w_seq + i_branch_offset;
  assign w_jmp = {w_seq[31:28], i_jump_low};
  assign w_jra = i_jr_addr;

  // Resolve which source wins when several requests coincide.
  always_comb begin
    w_sel = SEL_SEQ;
    if (i_jr)                w_sel = SEL_JR;
    else if (i_jump)         w_sel = SEL_J;
    else if (i_branch_taken) w_sel = SEL_BR;
  end

  // Route the winning candidate to the target output.
  always_comb begin
    o_target = w_seq;
    unique case (w_sel)
      SEL_SEQ: o_target = w_seq;
      SEL_BR:  o_target = w_br;
      SEL_J:   o_target = w_jmp;
      SEL_JR:  o_target = w_jra;
    endcase
  end

  assign o_pc_plus4   = w_seq;
  assign o_redirect   = (w_sel != SEL_SEQ);
  assign o_misaligned = o_redirect && is_misaligned(o_target[1:0]);

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the architectural pc, buffers redirects that
// arrive while fetch is stalled, and traps misaligned targets to a vector.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [27:0] jump_low,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        misalign_err,
  output logic [31:0] bad_addr
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic [31:0] r_bad;
  logic        r_err;

  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_misaligned;
  logic [31:0] w_commit;
  logic        w_commit_trap;

  next_pc_mux u_mux (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jump          (jump),
    .i_jump_low      (jump_low),
    .i_jr            (jr),
    .i_jr_addr       (jr_addr),
    .o_pc_plus4      (pc_plus4),
    .o_target        (w_target),
    .o_redirect      (w_redirect),
    .o_misaligned    (w_misaligned)
  );

  // Address committed on an unstalled edge: a fresh redirect beats the
  // buffered one; the buffered target is re-checked for alignment here so a
  // trap captured under stall fires only on release.
  always_comb begin
    w_commit      = w_target;
    w_commit_trap = w_misaligned;
    if (r_state == ST_HOLD && !w_redirect) begin
      w_commit      = r_pend;
      w_commit_trap = is_misaligned(r_pend[1:0]);
    end
  end

  // Stage FSM with pc, pending target, trap address and trap pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_bad   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (!stall) begin
            if (w_commit_trap) begin
              r_pc  <= EXC_VECTOR;
              r_bad <= w_commit;
              r_err <= 1'b1;
            end else begin
              r_pc <= w_commit;
            end
          end else if (w_redirect) begin
            r_pend  <= w_target;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (stall) begin
            if (w_redirect) r_pend <= w_target;
          end else begin
            r_state <= ST_RUN;
            if (w_commit_trap) begin
              r_pc  <= EXC_VECTOR;
              r_bad <= w_commit;
              r_err <= 1'b1;
            end else begin
              r_pc <= w_commit;
            end
          end
        end
      endcase
    end
  end

  assign pc               = r_pc;
  assign redirect_pending = (r_state == ST_HOLD);
  assign misalign_err     = r_err;
  assign bad_addr         = r_bad;

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter stage of the MIPS datapath. Holds the architectural PC and each cycle selects the next fetch address from four sources: sequential (PC+4), branch, jump and register jump. The jump source is the 28-bit word-aligned field produced by the shift-left-two stage, merged with PC+4[31:28]. Redirects that arrive during a fetch stall are buffered and applied on release, and misaligned targets are trapped to an exception vector.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned-target trap
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold PC (fetch not accepted this cycle)
- branch_taken  input  1  branch resolved taken (condition already evaluated)
- branch_offset  input  32  sign-extended immediate, already shifted left two
- jump  input  1  J/JAL redirect
- jump_low  input  28  shifted 26-bit jump field
- jr  input  1  JR/JALR redirect
- jr_addr  input  32  register-jump target
- pc  output  32  current fetch address
- pc_plus4  output  32  pc + 4, combinational from pc
- redirect_pending  output  1  a buffered redirect is waiting for stall release
- misalign_err  output  1  one-cycle pulse: trap taken this edge
- bad_addr  output  32  last trapped target address

## Operation
- Reset (asynchronous, any time): pc=RESET_PC, state=RUN, pending cleared, redirect_pending=0, misalign_err=0, bad_addr=0.
- Target computation, combinational from the current pc:
  - seq = pc_plus4
  - br = pc_plus4 + branch_offset
  - jmp = {pc_plus4[31:28], jump_low}
  - jra = jr_addr
- Priority when more than one request is asserted: jr > jump > branch_taken > sequential.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Alignment check applies to the selected redirect target. Any nonzero target[1:0] is a trap: pc←EXC_VECTOR, bad_addr←target, misalign_err=1 for one cycle. The jmp target is always aligned.
- State machine:
  - RUN, stall=0: pc←selected target, or the trap vector.
  - RUN, stall=1 with a redirect: capture the selected target in the pending register and go to HOLD. pc is unchanged.
  - RUN, stall=1 without a redirect: pc is unchanged and the state stays RUN.
  - HOLD, stall=1: pc is unchanged. A new redirect overwrites the pending target, with its target computed from the still-held pc.
  - HOLD, stall=0: a redirect asserted in that cycle wins. Otherwise pc←pending target, with the alignment check applied at this point. In both cases, go to RUN.
- redirect_pending = (state==HOLD).

## Timing
- pc updates on the rising edge of clk. Latency is one cycle from request to new pc.
- Requests are sampled at the same edge as stall. No handshake is needed beyond stall.
- misalign_err is registered. It is high only during the cycle after the trapping edge.
- A trap and a stall in the same cycle: the bad target is buffered, and the trap fires on release.
- A reset asserted while in HOLD discards the pending target.

## Structure
- Shared package holds RESET_PC/EXC_VECTOR defaults, the 2-bit source select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR) and the state encoding (ST_RUN, ST_HOLD).
- One natural sub-module, next_pc_mux, computes the four targets and selects by priority. It is purely combinational and outputs target plus misaligned. The top holds the FSM, pc, pending and bad_addr registers.

## Test plan
- Reset, then 3 unstalled cycles: pc = 0x0, then 0x4, 0x8, 0xC. After reset deasserts mid-cycle, pc is 0x0 immediately.
- pc=0x0040_0010, jump=1, jump_low=0x0000100: next pc=0x0000_0100. Repeat with pc=0x1000_0000: next pc=0x1000_0100.
- pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFF0, with jr=1 (jr_addr=0x200) in the same cycle: pc=0x200. With jr=0: pc=0xF4.
- jr_addr=0x0000_0202: pc=0x80 next cycle, misalign_err high for exactly one cycle, bad_addr=0x202.
- stall=1 while jump to 0x300 is requested, held 3 cycles: pc frozen, redirect_pending=1. Release: pc=0x300, redirect_pending=0. Then reset during HOLD: pc=RESET_PC and pending lost.
- pc=0xFFFF_FFFC, no redirect: next pc=0x0000_0000 and misalign_err=0.
